// File: rtl/lbus_access_ctrl.sv
// Wishbone-classic to local-bus access controller: captures a master cycle and
// drives a timed access window downstream. Optional timeout: define LBUS_TIMEOUT_EN.
module lbus_access_ctrl #(
    parameter int WB_DATA_WIDTH = 16,
    parameter int WB_ADDR_WIDTH = 16,
    parameter int HOLD_CYC      = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic                     CLK_32,
    input  logic                     RESET_N,
    input  logic                     Cyc_i,
    input  logic                     Stb_i,
    input  logic                     We_i,
    input  logic [WB_ADDR_WIDTH-1:0] Adr_i,
    input  logic [WB_DATA_WIDTH-1:0] Dat_i,
    output logic [WB_DATA_WIDTH-1:0] Dat_o,
    output logic                     Ack_o,
    output logic                     Err_o,
    output logic [WB_ADDR_WIDTH-1:0] Adr_slave_i_lbus_reg,
    output logic                     We_slave_i_lbus_reg,
    output logic [WB_DATA_WIDTH-1:0] Dat_slave_io_lbus,
    output logic                     ack_access_str,
    output logic                     ack_access_reg_3,
    input  logic                     ack_set_reg,
    input  logic [WB_DATA_WIDTH-1:0] Dat_slave_o_lbus,
    output logic                     Busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STR,
        S_WAIT,
        S_DONE,
        S_GAP
    } state_t;

    localparam logic [7:0] HOLD_C = 8'(HOLD_CYC);

    state_t                     r_state;
    state_t                     w_next;
    logic [7:0]                 r_cnt;
    logic [WB_DATA_WIDTH-1:0]   r_dat_o;
    logic [WB_ADDR_WIDTH-1:0]   r_adr;
    logic                       r_we;
    logic [WB_DATA_WIDTH-1:0]   r_dat;
    logic                       w_done_ok;

`ifdef LBUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYC);
    logic                       w_done_to;
    logic                       r_err;
`endif

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_done_ok = 1'b0;
`ifdef LBUS_TIMEOUT_EN
        w_done_to = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: if (Cyc_i && Stb_i) w_next = S_STR;
            S_STR:  w_next = Cyc_i ? S_WAIT : S_IDLE;
            S_WAIT: begin
                // A dropped cycle aborts even if the downstream completes now.
                if (!Cyc_i) begin
                    w_next = S_IDLE;
                end else if (ack_set_reg && (r_cnt >= HOLD_C)) begin
                    w_next    = S_DONE;
                    w_done_ok = 1'b1;
                end
`ifdef LBUS_TIMEOUT_EN
                else if (r_cnt >= TIMEOUT_C) begin
                    w_next    = S_DONE;
                    w_done_to = 1'b1;
                end
`endif
            end
            S_DONE: w_next = S_GAP;
            S_GAP:  if (!Stb_i || !Cyc_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK_32) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_dat_o <= '0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
`ifdef LBUS_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && w_next == S_STR) begin
                r_adr <= Adr_i;
                r_we  <= We_i;
                r_dat <= Dat_i;
            end

            if (r_state == S_STR) begin
                r_cnt <= 8'd1;
            end else if (r_state == S_WAIT) begin
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end

            if (w_done_ok && !r_we) r_dat_o <= Dat_slave_o_lbus;
`ifdef LBUS_TIMEOUT_EN
            if (w_done_to) r_dat_o <= '1;
            r_err <= w_done_to;
`endif
        end
    end

    assign Dat_o                = r_dat_o;
    assign Adr_slave_i_lbus_reg = r_adr;
    assign We_slave_i_lbus_reg  = r_we;
    assign Dat_slave_io_lbus    = r_dat;
    assign ack_access_str       = (r_state == S_STR);
    assign ack_access_reg_3     = (r_state == S_STR) || (r_state == S_WAIT);
    assign Busy_o               = (r_state != S_IDLE);

`ifdef LBUS_TIMEOUT_EN
    assign Ack_o = (r_state == S_DONE) && !r_err;
    assign Err_o = (r_state == S_DONE) &&  r_err;
`else
    assign Ack_o = (r_state == S_DONE);
    assign Err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lbus_access_ctrl.sv
// Directed bench for lbus_access_ctrl: table-driven write/read cycles plus
// hand sequences for held strobe, abort, timeout (LBUS_TIMEOUT_EN) and reset.
module tb_lbus_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we, ack_set;
    logic [15:0] adr, dat, sdat;
    logic [15:0] dat_o, s_adr, s_dat;
    logic        ack_o, err_o, s_we, str, reg3, busy;

    int checks = 0;
    int errors = 0;

    lbus_access_ctrl #(
        .WB_DATA_WIDTH(16),
        .WB_ADDR_WIDTH(16),
        .HOLD_CYC     (4),
        .TIMEOUT_CYC  (20)
    ) dut (
        .CLK_32              (clk),
        .RESET_N             (rst_n),
        .Cyc_i               (cyc),
        .Stb_i               (stb),
        .We_i                (we),
        .Adr_i               (adr),
        .Dat_i               (dat),
        .Dat_o               (dat_o),
        .Ack_o               (ack_o),
        .Err_o               (err_o),
        .Adr_slave_i_lbus_reg(s_adr),
        .We_slave_i_lbus_reg (s_we),
        .Dat_slave_io_lbus   (s_dat),
        .ack_access_str      (str),
        .ack_access_reg_3    (reg3),
        .ack_set_reg         (ack_set),
        .Dat_slave_o_lbus    (sdat),
        .Busy_o              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cyc, stb, we, ack_set;
        logic [15:0] adr, dat, sdat;
        logic        e_str, e_reg3, e_ack, e_busy;
        logic [15:0] e_dat_o;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic ak, input logic [15:0] sd);
        cyc = c; stb = s; we = w; adr = a; dat = d; ack_set = ak; sdat = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   ack_at;
        int   reg3_cnt;
        int   bad;

        // Write A001/801F then read A003 returning 8015, HOLD_CYC = 4.
        vecs[0]  = '{1,1,1,0,16'hA001,16'h801F,16'h0000, 1,1,0,1,16'h0000};
        vecs[1]  = '{1,1,1,1,16'hA001,16'h801F,16'h0000, 0,1,0,1,16'h0000};
        vecs[2]  = '{1,1,1,1,16'hA001,16'h801F,16'h0000, 0,1,0,1,16'h0000};
        vecs[3]  = '{1,1,1,1,16'hA001,16'h801F,16'h0000, 0,1,0,1,16'h0000};
        vecs[4]  = '{1,1,1,1,16'hA001,16'h801F,16'h0000, 0,1,0,1,16'h0000};
        vecs[5]  = '{1,1,1,1,16'hA001,16'h801F,16'h0000, 0,0,1,1,16'h0000};
        vecs[6]  = '{1,0,1,0,16'hA001,16'h801F,16'h0000, 0,0,0,1,16'h0000};
        vecs[7]  = '{0,0,0,0,16'h0000,16'h0000,16'h0000, 0,0,0,0,16'h0000};
        vecs[8]  = '{1,1,0,1,16'hA003,16'h0000,16'h8015, 1,1,0,1,16'h0000};
        vecs[9]  = '{1,1,0,1,16'hA003,16'h0000,16'h8015, 0,1,0,1,16'h0000};
        vecs[10] = '{1,1,0,1,16'hA003,16'h0000,16'h8015, 0,1,0,1,16'h0000};
        vecs[11] = '{1,1,0,1,16'hA003,16'h0000,16'h8015, 0,1,0,1,16'h0000};
        vecs[12] = '{1,1,0,1,16'hA003,16'h0000,16'h8015, 0,1,0,1,16'h0000};
        vecs[13] = '{1,1,0,1,16'hA003,16'h0000,16'h8015, 0,0,1,1,16'h8015};
        vecs[14] = '{1,1,0,0,16'hA003,16'h0000,16'h8015, 0,0,0,1,16'h8015};

        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        tick();
        tick();
        check("rst_dat_o", dat_o, 16'h0);
        check("rst_ack",   ack_o, 1'b0);
        check("rst_err",   err_o, 1'b0);
        check("rst_slave", {s_adr, s_dat}, 32'h0);
        check("rst_we",    s_we, 1'b0);
        check("rst_str_reg3_busy", {str, reg3, busy}, 3'b000);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].adr,
                  vecs[i].dat, vecs[i].ack_set, vecs[i].sdat);
            tick();
            check($sformatf("v%0d_str",   i), str,   vecs[i].e_str);
            check($sformatf("v%0d_reg3",  i), reg3,  vecs[i].e_reg3);
            check($sformatf("v%0d_ack",   i), ack_o, vecs[i].e_ack);
            check($sformatf("v%0d_err",   i), err_o, 1'b0);
            check($sformatf("v%0d_busy",  i), busy,  vecs[i].e_busy);
            check($sformatf("v%0d_dat_o", i), dat_o, vecs[i].e_dat_o);
            if (i == 5) begin
                check("wr_slave_adr", s_adr, 16'hA001);
                check("wr_slave_we",  s_we,  1'b1);
                check("wr_slave_dat", s_dat, 16'h801F);
            end
        end

        // Strobe held after Ack_o: must stay in GAP without a new access.
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (str !== 1'b0 || busy !== 1'b1 || ack_o !== 1'b0) bad++;
        end
        check("held_stb_no_retrigger", bad, 0);
        drive(1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        tick();
        check("held_stb_release_idle", busy, 1'b0);
        tick();
        check("held_stb_no_str_after", str, 1'b0);

        // Abort: Cyc_i dropped in the 2nd WAIT cycle while ack_set_reg is high.
        drive(1, 1, 0, 16'hE000, 16'h0, 0, 16'h1234);
        tick();
        check("abort_str", str, 1'b1);
        tick();
        ack_set = 1'b1;
        tick();
        check("abort_in_wait", {str, reg3}, 2'b01);
        cyc = 1'b0;
        tick();
        check("abort_idle", {busy, reg3, ack_o, err_o}, 4'b0000);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_o !== 1'b0 || err_o !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_no_term", bad, 0);
        check("abort_dat_o_kept", dat_o, 16'h8015);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        tick();

        // Downstream never completes.
        drive(1, 1, 0, 16'hB000, 16'h0, 0, 16'h5555);
        tick();
        check("to_str", str, 1'b1);
`ifdef LBUS_TIMEOUT_EN
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack_o !== 1'b0 || err_o !== 1'b0 || reg3 !== 1'b1) bad++;
        end
        check("to_wait_quiet", bad, 0);
        tick();
        check("to_err",   err_o, 1'b1);
        check("to_ack",   ack_o, 1'b0);
        check("to_reg3",  reg3,  1'b0);
        check("to_dat_o", dat_o, 16'hFFFF);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        tick();
        check("to_err_pulse", err_o, 1'b0);
        tick();
        check("to_idle", busy, 1'b0);
`else
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (ack_o !== 1'b0 || err_o !== 1'b0) bad++;
        end
        check("noto_no_term", bad, 0);
        check("noto_still_wait", {busy, reg3}, 2'b11);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        tick();
        check("noto_abort_idle", busy, 1'b0);
`endif

        // Reset in the middle of WAIT, then a normal write.
        drive(1, 1, 1, 16'hC00C, 16'h1234, 0, 16'h0);
        tick();
        tick();
        tick();
        check("mid_wait", reg3, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ctrl", {str, reg3, busy, ack_o, err_o}, 5'b00000);
        check("mid_rst_slave", {s_adr, s_dat}, 32'h0);
        check("mid_rst_we", s_we, 1'b0);
        check("mid_rst_dat_o", dat_o, 16'h0);
        rst_n = 1'b1;
        drive(1, 1, 1, 16'hD00D, 16'h4321, 1, 16'h0);
        ack_at = -1;
        reg3_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (reg3 === 1'b1) reg3_cnt++;
            if (ack_o === 1'b1 && ack_at < 0) ack_at = k;
            if (k == 8) stb = 1'b0;
        end
        check("post_rst_ack_tick", ack_at, 6);
        check("post_rst_reg3_len", reg3_cnt, 5);
        check("post_rst_slave", {s_adr, s_dat}, 32'hD00D4321);
        check("post_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
